data_sync_mc: RTL

//  Multi-channel successor to the single-bus data synchroniser. Each of NUM_CH

---
 rtl/data_sync_mc.sv | 108 ++++++++++
 1 files changed

// File: rtl/data_sync_mc.sv
// Multi-channel enable synchroniser: per-channel sync chain, edge capture, 2-phase ack and overrun flag.
// Captured words merge into a round-robin valid/ready stream; the stream holds its word while stalled.
module data_sync_mc #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_CH     = 4,
    parameter logic [NUM_CH-1:0] MODE = '0,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_CH*BUS_WIDTH-1:0]   unsync_bus,
    input  logic [NUM_CH-1:0]             bus_enable,
    output logic [NUM_CH*BUS_WIDTH-1:0]   sync_bus,
    output logic [NUM_CH-1:0]             enable_pulse,
    output logic [NUM_CH-1:0]             ack_toggle,
    output logic                          out_valid,
    output logic [BUS_WIDTH-1:0]          out_data,
    output logic [CH_W-1:0]               out_ch,
    input  logic                          out_ready,
    output logic [NUM_CH-1:0]             overrun,
    input  logic [NUM_CH-1:0]             clr_overrun
);

    logic [NUM_CH-1:0] stg [NUM_STAGES];
    logic [NUM_CH-1:0] last_q;
    logic [NUM_CH-1:0] evt;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] ld_hit;
    logic [CH_W-1:0]   rr;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   grant_hi;
    logic [CH_W-1:0]   grant_lo;
    logic              hi_vld;
    logic              load;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                stg[i] <= '0;
            end
            last_q <= '0;
        end else begin
            stg[0] <= bus_enable;
            for (int i = 1; i < NUM_STAGES; i++) begin
                stg[i] <= stg[i-1];
            end
            last_q <= stg[NUM_STAGES-1];
        end
    end

    // Toggle channels fire on either edge, level channels only on the rising edge.
    assign evt = (MODE & (stg[NUM_STAGES-1] ^ last_q)) |
                 (~MODE & stg[NUM_STAGES-1] & ~last_q);

    always_comb begin
        grant_hi = '0;
        grant_lo = '0;
        hi_vld   = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pending[c]) begin
                grant_lo = CH_W'(c);
            end
            if (pending[c] && (c >= int'(rr))) begin
                grant_hi = CH_W'(c);
                hi_vld   = 1'b1;
            end
        end
        grant = hi_vld ? grant_hi : grant_lo;
    end

    assign load   = (!out_valid || out_ready) && (|pending);
    assign ld_hit = load ? (NUM_CH'(1) << grant) : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_bus     <= '0;
            enable_pulse <= '0;
            ack_toggle   <= '0;
            pending      <= '0;
            overrun      <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_ch       <= '0;
            rr           <= '0;
        end else begin
            enable_pulse <= evt;
            ack_toggle   <= ack_toggle ^ evt;
            // A fresh event re-arms pending even when the old word leaves this cycle.
            pending      <= (pending & ~ld_hit) | evt;
            overrun      <= (overrun & ~clr_overrun) | (evt & pending & ~ld_hit);
            for (int c = 0; c < NUM_CH; c++) begin
                if (evt[c]) begin
                    sync_bus[c*BUS_WIDTH +: BUS_WIDTH] <= unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
                end
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= sync_bus[grant*BUS_WIDTH +: BUS_WIDTH];
                out_ch    <= grant;
                rr        <= (int'(grant) == NUM_CH - 1) ? '0 : grant + CH_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
